vmem_responder: RTL and testbench

Handshaked vector data-memory responder that serves LOAD/STORE requests from the SIMD GPU core over a valid/ready request channel and returns in-order responses over a valid/ready response channel. It replaces the bare always-ready data memory with a backpressure-aware target. It owns a 128-bit-line memory array (one line per address), supports per-lane masked stores and flags out-of-range addresses. Responses are buffered so the core may stall the response channel without dropping accesses.

---
 rtl/vmem_pkg.sv | 30 +++
 rtl/vmem_rsp_fifo.sv | 51 +++++
 rtl/vmem_responder.sv | 99 +++++++++
 tb/tb_vmem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// Shared types and helpers for the vector data-memory responder.
package vmem_pkg;

    localparam int unsigned VMEM_LANES  = 4;
    localparam int unsigned VMEM_ADDR_W = 8;
    localparam int unsigned LINE_W      = 32 * VMEM_LANES;

    // One buffered response; data is zero for stores and errors.
    typedef struct packed {
        logic                   we;
        logic                   err;
        logic [VMEM_ADDR_W-1:0] addr;
        logic [LINE_W-1:0]      data;
    } vmem_rsp_t;

    // Replace the 32-bit lanes of old_line whose mask bit is set.
    function automatic logic [LINE_W-1:0] lane_merge(
        input logic [LINE_W-1:0]     old_line,
        input logic [LINE_W-1:0]     new_line,
        input logic [VMEM_LANES-1:0] mask
    );
        logic [LINE_W-1:0] res;
        res = old_line;
        for (int unsigned i = 0; i < VMEM_LANES; i++) begin
            if (mask[i]) res[32*i +: 32] = new_line[32*i +: 32];
        end
        return res;
    endfunction

endpackage

// File: rtl/vmem_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; overflow is prevented
// upstream by credit flow control.
module vmem_rsp_fifo
    import vmem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  vmem_rsp_t                din_i,
    input  logic                     pop_i,
    output vmem_rsp_t                dout_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_ONE = 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    vmem_rsp_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_q;
    logic [PW-1:0]   rd_q;
    logic [PW:0]     cnt_q;

    // Entry storage; contents need no reset because the count gates validity.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    // Pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PTR_ONE;
            if (pop_i)  rd_q <= rd_q + PTR_ONE;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/vmem_responder.sv
// Handshaked vector data-memory responder: line array, one-cycle read
// stage, credit-based request flow control and buffered in-order responses.
// Optional feature macro: VMEM_LANE_MASK_EN (per-lane store masking).
module vmem_responder
    import vmem_pkg::*;
#(
    parameter int unsigned LANES     = VMEM_LANES,
    parameter int unsigned ADDR_W    = VMEM_ADDR_W,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [32*LANES-1:0]   req_wdata,
    input  logic [LANES-1:0]      req_mask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_we,
    output logic [ADDR_W-1:0]     rsp_addr,
    output logic [32*LANES-1:0]   rsp_rdata,
    output logic                  rsp_err
);

    logic [LINE_W-1:0]          mem_q [DEPTH];
    logic                       stg_valid_q;
    logic                       stg_valid_d;
    vmem_rsp_t                  stg_q;
    vmem_rsp_t                  stg_d;
    vmem_rsp_t                  head;
    logic [$clog2(RSP_DEPTH):0] fifo_cnt;
    logic                       accept;
    logic                       in_range;
    logic                       pop;
    logic [LANES-1:0]           wr_mask;

`ifdef VMEM_LANE_MASK_EN
    assign wr_mask = req_mask;
`else
    logic unused_mask;
    assign unused_mask = ^req_mask;
    assign wr_mask     = '1;
`endif

    // A slot is reserved for the request in the read stage, so the FIFO cannot overflow.
    assign req_ready = !reset
                     && ((int'(fifo_cnt) + int'(stg_valid_q)) < int'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign in_range  = 32'(req_addr) < 32'(DEPTH);

    // Masked store into the line array; out-of-range addresses never touch it.
    always_ff @(posedge clk) begin
        if (accept && req_we && in_range) begin
            mem_q[req_addr] <= lane_merge(mem_q[req_addr], req_wdata, wr_mask);
        end
    end

    // Next read-stage contents: load data captured at the accept edge.
    always_comb begin
        stg_valid_d = accept;
        stg_d.we    = req_we;
        stg_d.err   = !in_range;
        stg_d.addr  = req_addr;
        stg_d.data  = '0;
        if (accept && !req_we && in_range) stg_d.data = mem_q[req_addr];
    end

    // Read stage register; its contents are pushed into the FIFO one edge later.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid_q <= 1'b0;
            stg_q       <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_q       <= stg_d;
        end
    end

    vmem_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (stg_valid_q),
        .din_i   (stg_q),
        .pop_i   (pop),
        .dout_o  (head),
        .count_o (fifo_cnt)
    );

    assign rsp_valid = (fifo_cnt != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_we    = rsp_valid && head.we;
    assign rsp_err   = rsp_valid && head.err;
    assign rsp_addr  = rsp_valid ? head.addr : '0;
    assign rsp_rdata = rsp_valid ? head.data : '0;

endmodule

// File: tb/tb_vmem_responder.sv
// Scoreboard bench for vmem_responder (DEPTH=200 to exercise range errors).
module tb_vmem_responder;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_we = 1'b0;
    logic [7:0]   req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic [3:0]   req_mask = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic         rsp_we;
    logic [7:0]   rsp_addr;
    logic [127:0] rsp_rdata;
    logic         rsp_err;

    typedef struct packed {
        logic         we;
        logic         err;
        logic [7:0]   addr;
        logic [127:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   accepted = 0;

    logic [127:0] L9A, L9B_W, L9B, L5A, L5B_W, L5B, D199, JUNK;

    vmem_responder #(
        .LANES     (4),
        .ADDR_W    (8),
        .DEPTH     (200),
        .RSP_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_mask  (req_mask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_we    (rsp_we),
        .rsp_addr  (rsp_addr),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request, wait (bounded) for acceptance, record its expected response.
    task automatic issue(input logic we, input logic [7:0] addr, input logic [127:0] wd,
                         input logic [3:0] m, input logic [127:0] exp_data, input logic exp_err);
        int n = 0;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_mask  = m;
        #1;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready 0 expected 1 (addr %0d)", addr);
        end else begin
            e.we = we; e.err = exp_err; e.addr = addr; e.data = exp_data;
            sb.push_back(e);
            accepted++;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic set_rsp_ready(input logic v);
        @(posedge clk);
        #1 rsp_ready = v;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 128'(sb.size()), 128'd0);
    endtask

    // Monitor: every handshaked response is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got addr %0d expected no response", rsp_addr);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_we",    128'(rsp_we),   128'(mon_e.we));
                chk("rsp_err",   128'(rsp_err),  128'(mon_e.err));
                chk("rsp_addr",  128'(rsp_addr), 128'(mon_e.addr));
                chk("rsp_rdata", rsp_rdata,      mon_e.data);
            end
        end
    end

    initial begin
        L9A   = {32'd4,  32'd3,  32'd2,  32'd1};
        L9B_W = {32'd40, 32'd30, 32'd20, 32'd10};
        L5A   = {32'd8,  32'd7,  32'd6,  32'd5};
        L5B_W = {32'd13, 32'd12, 32'd11, 32'd10};
        D199  = {32'd99, 32'd98, 32'd97, 32'd96};
        JUNK  = {4{32'hDEAD_BEEF}};
`ifdef VMEM_LANE_MASK_EN
        L9B = {32'd4, 32'd30, 32'd2,  32'd10};
        L5B = {32'd8, 32'd7,  32'd11, 32'd10};
`else
        L9B = L9B_W;
        L5B = L5B_W;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 128'(req_ready), 128'd0);
        chk("reset_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("reset_rsp_we",    128'(rsp_we),    128'd0);
        chk("reset_rsp_addr",  128'(rsp_addr),  128'd0);
        chk("reset_rsp_rdata", rsp_rdata,       128'd0);
        chk("reset_rsp_err",   128'(rsp_err),   128'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 128'(req_ready), 128'd1);

        // Full store then load
        issue(1'b1, 8'd9, L9A, 4'hF, '0, 1'b0);
        issue(1'b0, 8'd9, '0,  4'h0, L9A, 1'b0);
        // Partial-mask store over known line
        issue(1'b1, 8'd9, L9B_W, 4'b0101, '0, 1'b0);
        issue(1'b0, 8'd9, '0,    4'hF,    L9B, 1'b0);
        // Store followed immediately by load of the same line
        issue(1'b1, 8'd5, L5A,   4'hF,    '0,  1'b0);
        issue(1'b0, 8'd5, '0,    4'h0,    L5A, 1'b0);
        issue(1'b1, 8'd5, L5B_W, 4'b0011, '0,  1'b0);
        issue(1'b0, 8'd5, '0,    4'h0,    L5B, 1'b0);
        // Range boundary and out-of-range accesses
        issue(1'b1, 8'd199, D199, 4'hF, '0,   1'b0);
        issue(1'b1, 8'd250, JUNK, 4'hF, '0,   1'b1);
        issue(1'b0, 8'd250, '0,   4'hF, '0,   1'b1);
        issue(1'b0, 8'd200, '0,   4'hF, '0,   1'b1);
        issue(1'b0, 8'd199, '0,   4'hF, D199, 1'b0);
        idle();
        drain();

        // Backpressure: six loads with the response channel stalled
        set_rsp_ready(1'b0);
        accepted = 0;
        fork
            begin
                issue(1'b0, 8'd9,   '0, 4'h0, L9B,  1'b0);
                issue(1'b0, 8'd5,   '0, 4'h0, L5B,  1'b0);
                issue(1'b0, 8'd199, '0, 4'h0, D199, 1'b0);
                issue(1'b0, 8'd9,   '0, 4'h0, L9B,  1'b0);
                issue(1'b0, 8'd5,   '0, 4'h0, L5B,  1'b0);
                issue(1'b0, 8'd199, '0, 4'h0, D199, 1'b0);
                idle();
            end
            begin
                repeat (12) @(negedge clk);
                #1;
                chk("stall_accepted",  128'(accepted),  128'd4);
                chk("stall_req_ready", 128'(req_ready), 128'd0);
                chk("stall_rsp_valid", 128'(rsp_valid), 128'd1);
                chk("stall_head_addr", 128'(rsp_addr),  128'd9);
                chk("stall_head_data", rsp_rdata,       L9B);
                set_rsp_ready(1'b1);
            end
        join
        drain();
        chk("stall_total_accepted", 128'(accepted), 128'd6);

        // Reset with three responses buffered; a store presented during reset is dropped
        set_rsp_ready(1'b0);
        issue(1'b0, 8'd9,   '0, 4'h0, L9B,  1'b0);
        issue(1'b0, 8'd5,   '0, 4'h0, L5B,  1'b0);
        issue(1'b0, 8'd199, '0, 4'h0, D199, 1'b0);
        idle();
        repeat (3) @(negedge clk);
        chk("buffered_rsp_valid", 128'(rsp_valid), 128'd1);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'd9;
        req_wdata = JUNK;
        req_mask  = 4'hF;
        sb.delete();
        @(negedge clk);
        chk("midreset_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("midreset_req_ready", 128'(req_ready), 128'd0);
        req_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        chk("postreset_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("postreset_req_ready", 128'(req_ready), 128'd1);
        set_rsp_ready(1'b1);
        issue(1'b0, 8'd9, '0, 4'h0, L9B, 1'b0);
        issue(1'b0, 8'd5, '0, 4'h0, L5B, 1'b0);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
